pc_seq: RTL and testbench

Parametrised program sequencer that supersedes the fixed 8-bit program counter in the single-cycle core. It holds the fetch address, resolves conditional and unconditional relative branches, and adds a start/halt handshake with a selectable program entry point. It also provides an optional return-address stack (RAS) for CALL/RET. It drives the instruction-memory address and sits between the decoder/ALU flags and instruction ROM.

---
 rtl/pc_seq.sv | 184 ++++++++++++++++++
 tb/tb_pc_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq.sv
// pc_seq: program sequencer with IDLE/RUN/DONE start-halt FSM, relative branches and an
// optional return-address stack, enabled by defining PC_SEQ_RAS_EN (CALL acts as BA, RET as PC+1 without it).
package pc_seq_pkg;
  localparam logic [4:0] OP_BA   = 5'h01;
  localparam logic [4:0] OP_BL   = 5'h02;
  localparam logic [4:0] OP_BG   = 5'h03;
  localparam logic [4:0] OP_BE   = 5'h04;
  localparam logic [4:0] OP_CALL = 5'h05;
  localparam logic [4:0] OP_RET  = 5'h06;
  localparam logic [4:0] OP_HALT = 5'h07;
endpackage

module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int          PC_W      = 8,
  parameter int          BAMT_W    = 15,
  parameter int          RAS_DEPTH = 4,
  parameter int unsigned ENTRY0    = 0,
  parameter int unsigned ENTRY1    = 25,
  parameter int unsigned ENTRY2    = 44,
  parameter int unsigned ENTRY3    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        prog_sel,
  input  logic              stall,
  input  logic [4:0]        op,
  input  logic              z,
  input  logic              lt,
  input  logic [BAMT_W-1:0] bamt,
  output logic [PC_W-1:0]   PC,
  output logic              busy,
  output logic              done,
  output logic              ras_ovf,
  output logic              ras_unf
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic [PC_W-1:0] w_off, w_pc_inc, w_pc_br, w_entry;
  logic            w_clr;

  if (BAMT_W < PC_W) begin : g_sext
    assign w_off = {{(PC_W-BAMT_W){bamt[BAMT_W-1]}}, bamt};
  end else begin : g_trunc
    assign w_off = bamt[PC_W-1:0];
    if (BAMT_W > PC_W) begin : g_hi
      logic w_unused_bamt_hi;
      assign w_unused_bamt_hi = ^bamt[BAMT_W-1:PC_W];
    end
  end

  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_pc_br  = r_pc + w_off;

  always_comb begin
    w_entry = PC_W'(ENTRY0);
    case (prog_sel)
      2'd1:    w_entry = PC_W'(ENTRY1);
      2'd2:    w_entry = PC_W'(ENTRY2);
      2'd3:    w_entry = PC_W'(ENTRY3);
      default: w_entry = PC_W'(ENTRY0);
    endcase
  end

`ifdef PC_SEQ_RAS_EN
  localparam int SP_W  = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [PC_W-1:0] r_ras [RAS_DEPTH];
  logic [SP_W-1:0] r_sp, w_sp_dec;
  logic            r_ovf, r_unf;
  logic            w_push, w_pop, w_ovf_set, w_unf_set, w_full, w_empty;

  assign w_full   = (r_sp == SP_W'(RAS_DEPTH));
  assign w_empty  = (r_sp == '0);
  assign w_sp_dec = r_sp - SP_W'(1);
`else
  localparam int unused_ras_depth = RAS_DEPTH;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_clr       = 1'b0;
`ifdef PC_SEQ_RAS_EN
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = w_entry;
          w_clr       = 1'b1;
        end
      end
      S_RUN: begin
        if (!stall) begin
          case (op)
            OP_BA: w_pc_nxt = w_pc_br;
            OP_BL: w_pc_nxt = lt  ? w_pc_br : w_pc_inc;
            OP_BG: w_pc_nxt = !lt ? w_pc_br : w_pc_inc;
            OP_BE: w_pc_nxt = z   ? w_pc_br : w_pc_inc;
            OP_CALL: begin
              // A full stack loses the return address but the branch is still taken.
              w_pc_nxt = w_pc_br;
`ifdef PC_SEQ_RAS_EN
              if (w_full) w_ovf_set = 1'b1;
              else        w_push    = 1'b1;
`endif
            end
            OP_RET: begin
`ifdef PC_SEQ_RAS_EN
              if (w_empty) begin
                w_unf_set = 1'b1;
                w_pc_nxt  = w_pc_inc;
              end else begin
                w_pop    = 1'b1;
                w_pc_nxt = r_ras[IDX_W'(w_sp_dec)];
              end
`else
              w_pc_nxt = w_pc_inc;
`endif
            end
            OP_HALT: w_state_nxt = S_DONE;
            default: w_pc_nxt = w_pc_inc;
          endcase
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

`ifdef PC_SEQ_RAS_EN
  always_ff @(posedge clk) begin
    if (w_push) r_ras[IDX_W'(r_sp)] <= w_pc_inc;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (w_clr) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_push)    r_sp  <= r_sp + SP_W'(1);
      if (w_pop)     r_sp  <= w_sp_dec;
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_unf_set) r_unf <= 1'b1;
    end
  end

  assign ras_ovf = r_ovf;
  assign ras_unf = r_unf;
`else
  assign ras_ovf = 1'b0;
  assign ras_unf = 1'b0;
`endif

  assign PC   = r_pc;
  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: each step pushes the expected post-edge state, then pops and compares it.
module tb_pc_seq;
  import pc_seq_pkg::*;

`ifdef PC_SEQ_RAS_EN
  localparam int RAS = 1;
`else
  localparam int RAS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, stall, z, lt;
  logic [1:0]  prog_sel;
  logic [4:0]  op;
  logic [14:0] bamt;
  logic [7:0]  PC;
  logic        busy, done, ras_ovf, ras_unf;

  typedef struct {
    logic [7:0] pc;
    logic       busy;
    logic       done;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  pc_seq #(.PC_W(8), .BAMT_W(15), .RAS_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .stall(stall),
    .op(op), .z(z), .lt(lt), .bamt(bamt), .PC(PC), .busy(busy), .done(done),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int p, input int b, input int d, input int o, input int u);
    exp_t e;
    e.pc   = 8'(p);
    e.busy = 1'(b);
    e.done = 1'(d);
    e.ovf  = 1'(o);
    e.unf  = 1'(u);
    return e;
  endfunction

  task automatic drive(input int rst, input int st, input int sel, input int stl,
                       input logic [4:0] o, input int zz, input int ll, input int b, input exp_t e);
    @(negedge clk);
    reset    = 1'(rst);
    start    = 1'(st);
    prog_sel = 2'(sel);
    stall    = 1'(stl);
    op       = o;
    z        = 1'(zz);
    lt       = 1'(ll);
    bamt     = 15'(b);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t g;
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 1, 0, 5'h00, 0, 0, 0, mk(0, 0, 0, 0, 0));
      g = sb.pop_front(); n_chk++;
      if (PC !== g.pc || busy !== g.busy || done !== g.done || ras_ovf !== g.ovf || ras_unf !== g.unf)
        $display("FAIL reset[%0d] got pc=%0d busy=%b done=%b ovf=%b unf=%b want pc=%0d busy=%b done=%b ovf=%b unf=%b",
                 i, PC, busy, done, ras_ovf, ras_unf, g.pc, g.busy, g.done, g.ovf, g.unf);
      else n_pass++;
    end
  endtask

  task automatic test_start();
    exp_t g;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(1, 1, 1, 0, 5'h00, 0, 0, 0, mk(25, 1, 0, 0, 0));
        1: drive(1, 0, 0, 0, 5'h00, 0, 0, 0, mk(26, 1, 0, 0, 0));
        2: drive(1, 0, 0, 0, 5'h00, 0, 0, 0, mk(27, 1, 0, 0, 0));
        default: drive(1, 1, 2, 0, 5'h1F, 0, 0, 9, mk(28, 1, 0, 0, 0));
      endcase
      g = sb.pop_front(); n_chk++;
      if (PC !== g.pc || busy !== g.busy || done !== g.done || ras_ovf !== g.ovf || ras_unf !== g.unf)
        $display("FAIL start[%0d] got pc=%0d busy=%b done=%b ovf=%b unf=%b want pc=%0d busy=%b done=%b ovf=%b unf=%b",
                 i, PC, busy, done, ras_ovf, ras_unf, g.pc, g.busy, g.done, g.ovf, g.unf);
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    exp_t g;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: drive(1, 0, 0, 0, OP_BA, 0, 0, -18, mk(10, 1, 0, 0, 0));
        1: drive(1, 0, 0, 0, OP_BE, 1, 0, -3,  mk(7, 1, 0, 0, 0));
        2: drive(1, 0, 0, 0, OP_BA, 0, 0, 3,   mk(10, 1, 0, 0, 0));
        3: drive(1, 0, 0, 0, OP_BE, 0, 0, -3,  mk(11, 1, 0, 0, 0));
        4: drive(1, 0, 0, 0, OP_BL, 0, 1, 5,   mk(16, 1, 0, 0, 0));
        5: drive(1, 0, 0, 0, OP_BL, 1, 0, 5,   mk(17, 1, 0, 0, 0));
        6: drive(1, 0, 0, 0, OP_BG, 0, 0, 5,   mk(22, 1, 0, 0, 0));
        7: drive(1, 0, 0, 0, OP_BG, 1, 1, 5,   mk(23, 1, 0, 0, 0));
        default: drive(1, 0, 0, 1, OP_BA, 0, 0, 5, mk(23, 1, 0, 0, 0));
      endcase
      g = sb.pop_front(); n_chk++;
      if (PC !== g.pc || busy !== g.busy || done !== g.done || ras_ovf !== g.ovf || ras_unf !== g.unf)
        $display("FAIL branch[%0d] got pc=%0d busy=%b done=%b ovf=%b unf=%b want pc=%0d busy=%b done=%b ovf=%b unf=%b",
                 i, PC, busy, done, ras_ovf, ras_unf, g.pc, g.busy, g.done, g.ovf, g.unf);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    exp_t g;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(1, 0, 0, 0, OP_BA, 0, 0, 227,     mk(250, 1, 0, 0, 0));
        1: drive(1, 0, 0, 0, OP_BA, 0, 0, 10,      mk(4, 1, 0, 0, 0));
        2: drive(1, 0, 0, 0, OP_BA, 0, 0, 'h7FFF,  mk(3, 1, 0, 0, 0));
        3: drive(1, 0, 0, 0, OP_BA, 0, 0, -4,      mk(255, 1, 0, 0, 0));
        default: drive(1, 0, 0, 0, 5'h00, 0, 0, 0, mk(0, 1, 0, 0, 0));
      endcase
      g = sb.pop_front(); n_chk++;
      if (PC !== g.pc || busy !== g.busy || done !== g.done || ras_ovf !== g.ovf || ras_unf !== g.unf)
        $display("FAIL wrap[%0d] got pc=%0d busy=%b done=%b ovf=%b unf=%b want pc=%0d busy=%b done=%b ovf=%b unf=%b",
                 i, PC, busy, done, ras_ovf, ras_unf, g.pc, g.busy, g.done, g.ovf, g.unf);
      else n_pass++;
    end
  endtask

  task automatic test_ras();
    exp_t g;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: drive(1, 0, 0, 0, OP_BA,   0, 0, 5,  mk(5, 1, 0, 0, 0));
        1: drive(1, 0, 0, 0, OP_CALL, 0, 0, 10, mk(15, 1, 0, 0, 0));
        2: drive(1, 0, 0, 0, OP_BA,   0, 0, 5,  mk(20, 1, 0, 0, 0));
        3: drive(1, 0, 0, 0, OP_CALL, 0, 0, 10, mk(30, 1, 0, 0, 0));
        4: drive(1, 0, 0, 0, OP_CALL, 0, 0, 10, mk(40, 1, 0, RAS, 0));
        5: drive(1, 0, 0, 0, OP_RET,  0, 0, 0,  mk(RAS ? 21 : 41, 1, 0, RAS, 0));
        6: drive(1, 0, 0, 0, OP_RET,  0, 0, 0,  mk(RAS ? 6 : 42, 1, 0, RAS, 0));
        7: drive(1, 0, 0, 0, OP_RET,  0, 0, 0,  mk(RAS ? 7 : 43, 1, 0, RAS, RAS));
        default: drive(1, 0, 0, 0, OP_BA, 0, 0, RAS ? 33 : -3, mk(40, 1, 0, RAS, RAS));
      endcase
      g = sb.pop_front(); n_chk++;
      if (PC !== g.pc || busy !== g.busy || done !== g.done || ras_ovf !== g.ovf || ras_unf !== g.unf)
        $display("FAIL ras[%0d] got pc=%0d busy=%b done=%b ovf=%b unf=%b want pc=%0d busy=%b done=%b ovf=%b unf=%b",
                 i, PC, busy, done, ras_ovf, ras_unf, g.pc, g.busy, g.done, g.ovf, g.unf);
      else n_pass++;
    end
  endtask

  task automatic test_halt();
    exp_t g;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0, 1, 2: drive(1, 0, 0, 1, OP_HALT, 0, 0, 0, mk(40, 1, 0, RAS, RAS));
        3: drive(1, 0, 0, 0, OP_HALT, 0, 0, 0, mk(40, 0, 1, RAS, RAS));
        4: drive(1, 0, 0, 0, 5'h00,   0, 0, 0, mk(40, 0, 1, RAS, RAS));
        5: drive(1, 0, 0, 0, OP_BA,   0, 0, 5, mk(40, 0, 1, RAS, RAS));
        default: drive(1, 1, 2, 0, 5'h00, 0, 0, 0, mk(44, 1, 0, 0, 0));
      endcase
      g = sb.pop_front(); n_chk++;
      if (PC !== g.pc || busy !== g.busy || done !== g.done || ras_ovf !== g.ovf || ras_unf !== g.unf)
        $display("FAIL halt[%0d] got pc=%0d busy=%b done=%b ovf=%b unf=%b want pc=%0d busy=%b done=%b ovf=%b unf=%b",
                 i, PC, busy, done, ras_ovf, ras_unf, g.pc, g.busy, g.done, g.ovf, g.unf);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t g;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(1, 0, 0, 0, OP_CALL, 0, 0, 10, mk(54, 1, 0, 0, 0));
        1: drive(1, 0, 0, 0, OP_CALL, 0, 0, 10, mk(64, 1, 0, 0, 0));
        2: drive(0, 0, 0, 0, OP_RET,  0, 0, 0,  mk(0, 0, 0, 0, 0));
        3: drive(1, 1, 3, 1, 5'h00,   0, 0, 0,  mk(0, 1, 0, 0, 0));
        default: drive(1, 0, 0, 0, OP_RET, 0, 0, 0, mk(1, 1, 0, 0, RAS));
      endcase
      g = sb.pop_front(); n_chk++;
      if (PC !== g.pc || busy !== g.busy || done !== g.done || ras_ovf !== g.ovf || ras_unf !== g.unf)
        $display("FAIL midreset[%0d] got pc=%0d busy=%b done=%b ovf=%b unf=%b want pc=%0d busy=%b done=%b ovf=%b unf=%b",
                 i, PC, busy, done, ras_ovf, ras_unf, g.pc, g.busy, g.done, g.ovf, g.unf);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t g;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(1, 0, 0, 1, OP_CALL, 0, 0, 10, mk(1, 1, 0, 0, RAS));
        1: drive(1, 0, 0, 0, OP_CALL, 0, 0, 10, mk(11, 1, 0, 0, RAS));
        2: drive(1, 0, 0, 0, OP_RET,  0, 0, 0,  mk(RAS ? 2 : 12, 1, 0, 0, RAS));
        default: drive(1, 0, 0, 0, OP_HALT, 0, 0, 0, mk(RAS ? 2 : 12, 0, 1, 0, RAS));
      endcase
      g = sb.pop_front(); n_chk++;
      if (PC !== g.pc || busy !== g.busy || done !== g.done || ras_ovf !== g.ovf || ras_unf !== g.unf)
        $display("FAIL b2b[%0d] got pc=%0d busy=%b done=%b ovf=%b unf=%b want pc=%0d busy=%b done=%b ovf=%b unf=%b",
                 i, PC, busy, done, ras_ovf, ras_unf, g.pc, g.busy, g.done, g.ovf, g.unf);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; prog_sel = 2'd0; stall = 1'b0;
    op = 5'h00; z = 1'b0; lt = 1'b0; bamt = 15'd0;
    test_reset();
    test_start();
    test_branch();
    test_wrap();
    test_ras();
    test_halt();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
